// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        PhcIdle   = 1'b0,
        PhcMcBusy = 1'b1
    } phc_state_e;

    localparam int unsigned MulCyclesDef = 3;
    localparam int unsigned DivCyclesDef = 33;
    localparam int unsigned HazCntW      = 32;
    localparam int unsigned McCntW       = 8;
    localparam int unsigned RegAddrW     = 5;

    typedef logic [RegAddrW-1:0] reg_addr_t;
    typedef logic [McCntW-1:0]   mc_cnt_t;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic src_hit(logic used, reg_addr_t addr, reg_addr_t waddr);
        return used & (addr != '0) & (addr == waddr);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush controls and perf counters out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import pipe_hazard_ctrl_pkg::*;

    reg_addr_t          id_rs1_addr;
    reg_addr_t          id_rs2_addr;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic               alu_valid;
    logic               alu_is_load;
    logic               alu_reg_we;
    reg_addr_t          alu_reg_waddr;
    logic               alu_is_mul;
    logic               alu_is_div;
    logic               alu_redirect;
    logic               mem_busy;

    logic               stall_pc;
    logic               stall_if_id;
    logic               stall_id_alu;
    logic               stall_alu_mem;
    logic               flush_if_id;
    logic               flush_id_alu;
    logic               flush_alu_mem;
    logic               flush_mem_wb;
    logic               mc_done;
    logic [CNT_W-1:0]   cnt_loaduse;
    logic [CNT_W-1:0]   cnt_mc;
    logic [CNT_W-1:0]   cnt_memwait;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               alu_valid, alu_is_load, alu_reg_we, alu_reg_waddr,
               alu_is_mul, alu_is_div, alu_redirect, mem_busy,
        input  stall_pc, stall_if_id, stall_id_alu, stall_alu_mem,
               flush_if_id, flush_id_alu, flush_alu_mem, flush_mem_wb,
               mc_done, cnt_loaduse, cnt_mc, cnt_memwait
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               alu_valid, alu_is_load, alu_reg_we, alu_reg_waddr,
               alu_is_mul, alu_is_div, alu_redirect, mem_busy,
        output stall_pc, stall_if_id, stall_id_alu, stall_alu_mem,
               flush_if_id, flush_id_alu, flush_alu_mem, flush_mem_wb,
               mc_done, cnt_loaduse, cnt_mc, cnt_memwait
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module phc_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, mul/div occupancy,
// memory wait and branch squash, plus per-class stall counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MulCyclesDef,
    parameter int unsigned DIV_CYCLES = DivCyclesDef,
    parameter int unsigned CNT_W      = HazCntW
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    phc_state_e state_d, state_q;
    mc_cnt_t    mc_cnt_d, mc_cnt_q;

    logic loaduse, mc_req;
    logic inc_loaduse, inc_mc, inc_memwait;
    logic stall_pc, stall_if_id, stall_id_alu, stall_alu_mem;
    logic flush_if_id, flush_id_alu, flush_alu_mem, flush_mem_wb, mc_done;

    assign loaduse = bus.alu_valid & bus.alu_is_load & bus.alu_reg_we &
                     (src_hit(bus.id_rs1_used, bus.id_rs1_addr, bus.alu_reg_waddr) |
                      src_hit(bus.id_rs2_used, bus.id_rs2_addr, bus.alu_reg_waddr));
    assign mc_req  = bus.alu_valid & (bus.alu_is_mul | bus.alu_is_div);

    always_comb begin
        state_d       = state_q;
        mc_cnt_d      = mc_cnt_q;
        inc_loaduse   = 1'b0;
        inc_mc        = 1'b0;
        inc_memwait   = 1'b0;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_alu  = 1'b0;
        stall_alu_mem = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_alu  = 1'b0;
        flush_alu_mem = 1'b0;
        flush_mem_wb  = 1'b0;
        mc_done       = 1'b0;

        if (rst_n) begin
            state_d  = PhcIdle;
            mc_cnt_d = '0;
        end else if (bus.mem_busy) begin
            // Whole front end frozen; ALU-stage events re-present once MEM releases.
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_alu  = 1'b1;
            stall_alu_mem = 1'b1;
            flush_mem_wb  = 1'b1;
            inc_memwait   = 1'b1;
        end else if (state_q == PhcMcBusy) begin
            if (mc_cnt_q != '0) begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_alu  = 1'b1;
                flush_alu_mem = 1'b1;
                mc_cnt_d      = mc_cnt_q - 1'b1;
                inc_mc        = 1'b1;
            end else begin
                mc_done = 1'b1;
                state_d = PhcIdle;
            end
        end else if (bus.alu_redirect) begin
            flush_if_id  = 1'b1;
            flush_id_alu = 1'b1;
        end else if (mc_req) begin
            // First occupancy cycle stalls here, so the counter loads N-2 to finish on cycle N.
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_alu  = 1'b1;
            flush_alu_mem = 1'b1;
            mc_cnt_d      = bus.alu_is_div ? mc_cnt_t'(DIV_CYCLES - 2) :
                                             mc_cnt_t'(MUL_CYCLES - 2);
            state_d       = PhcMcBusy;
            inc_mc        = 1'b1;
        end else if (loaduse) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            flush_id_alu = 1'b1;
            inc_loaduse  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        mc_cnt_q <= mc_cnt_d;
    end

    assign bus.stall_pc      = stall_pc;
    assign bus.stall_if_id   = stall_if_id;
    assign bus.stall_id_alu  = stall_id_alu;
    assign bus.stall_alu_mem = stall_alu_mem;
    assign bus.flush_if_id   = flush_if_id;
    assign bus.flush_id_alu  = flush_id_alu;
    assign bus.flush_alu_mem = flush_alu_mem;
    assign bus.flush_mem_wb  = flush_mem_wb;
    assign bus.mc_done       = mc_done;

    phc_sat_counter #(.CNT_W(CNT_W)) u_cnt_loaduse (
        .clk_i (clk),
        .clr_i (rst_n),
        .inc_i (inc_loaduse),
        .cnt_o (bus.cnt_loaduse)
    );

    phc_sat_counter #(.CNT_W(CNT_W)) u_cnt_mc (
        .clk_i (clk),
        .clr_i (rst_n),
        .inc_i (inc_mc),
        .cnt_o (bus.cnt_mc)
    );

    phc_sat_counter #(.CNT_W(CNT_W)) u_cnt_memwait (
        .clk_i (clk),
        .clr_i (rst_n),
        .inc_i (inc_memwait),
        .cnt_o (bus.cnt_memwait)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 6;

    // {stall_pc, stall_if_id, stall_id_alu, stall_alu_mem,
    //  flush_if_id, flush_id_alu, flush_alu_mem, flush_mem_wb, mc_done}
    localparam logic [8:0] ONone = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] OLu   = 9'b1_1_0_0_0_1_0_0_0;
    localparam logic [8:0] OMc   = 9'b1_1_1_0_0_0_1_0_0;
    localparam logic [8:0] OMem  = 9'b1_1_1_1_0_0_0_1_0;
    localparam logic [8:0] ORd   = 9'b0_0_0_0_1_1_0_0_0;
    localparam logic [8:0] ODone = 9'b0_0_0_0_0_0_0_0_1;

    localparam int ClsNone = 0;
    localparam int ClsLu   = 1;
    localparam int ClsMc   = 2;
    localparam int ClsMw   = 3;
    localparam int ClsRst  = 4;

    typedef struct {
        string           tag;
        logic [8:0]      outs;
        logic [CW-1:0]   lu;
        logic [CW-1:0]   mc;
        logic [CW-1:0]   mw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    exp_t          sb_q[$];
    logic [CW-1:0] m_lu, m_mc, m_mw;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .MUL_CYCLES (3),
        .DIV_CYCLES (33),
        .CNT_W      (CW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.id_rs1_addr   = '0;
        bus.id_rs2_addr   = '0;
        bus.id_rs1_used   = 1'b0;
        bus.id_rs2_used   = 1'b0;
        bus.alu_valid     = 1'b0;
        bus.alu_is_load   = 1'b0;
        bus.alu_reg_we    = 1'b0;
        bus.alu_reg_waddr = '0;
        bus.alu_is_mul    = 1'b0;
        bus.alu_is_div    = 1'b0;
        bus.alu_redirect  = 1'b0;
        bus.mem_busy      = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] waddr);
        bus.alu_valid     = 1'b1;
        bus.alu_is_load   = 1'b1;
        bus.alu_reg_we    = 1'b1;
        bus.alu_reg_waddr = waddr;
    endtask

    // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic step(input string tag, input logic [8:0] exp_o, input int cls);
        exp_t e;
        logic [8:0] obs;
        case (cls)
            ClsLu:   m_lu = sat_inc(m_lu);
            ClsMc:   m_mc = sat_inc(m_mc);
            ClsMw:   m_mw = sat_inc(m_mw);
            ClsRst:  begin m_lu = '0; m_mc = '0; m_mw = '0; end
            default: ;
        endcase
        e.tag = tag; e.outs = exp_o; e.lu = m_lu; e.mc = m_mc; e.mw = m_mw;
        sb_q.push_back(e);
        #2;
        obs = {bus.stall_pc, bus.stall_if_id, bus.stall_id_alu, bus.stall_alu_mem,
               bus.flush_if_id, bus.flush_id_alu, bus.flush_alu_mem, bus.flush_mem_wb,
               bus.mc_done};
        chk({tag, ".outs"}, 32'(obs), 32'(sb_q[0].outs));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, ".cnt_loaduse"}, 32'(bus.cnt_loaduse), 32'(e.lu));
        chk({e.tag, ".cnt_mc"},      32'(bus.cnt_mc),      32'(e.mc));
        chk({e.tag, ".cnt_memwait"}, 32'(bus.cnt_memwait), 32'(e.mw));
    endtask

    initial begin
        m_lu = '0; m_mc = '0; m_mw = '0;
        clear_in();
        rst_n        = 1'b1;
        bus.mem_busy = 1'b1;
        @(posedge clk);
        #1;
        // Reset must mask an otherwise-stalling input.
        step("reset", ONone, ClsRst);
        rst_n = 1'b0;
        clear_in();
        step("idle", ONone, ClsNone);

        set_load(5'd5);
        bus.id_rs1_used = 1'b1; bus.id_rs1_addr = 5'd5;
        step("lu_rs1", OLu, ClsLu);
        clear_in();
        step("lu_after", ONone, ClsNone);

        set_load(5'd0);
        bus.id_rs1_used = 1'b1; bus.id_rs1_addr = 5'd0;
        step("lu_x0", ONone, ClsNone);
        clear_in();
        set_load(5'd7);
        bus.id_rs2_used = 1'b1; bus.id_rs2_addr = 5'd7;
        bus.id_rs1_used = 1'b1; bus.id_rs1_addr = 5'd3;
        step("lu_rs2", OLu, ClsLu);
        bus.id_rs2_used = 1'b0;
        step("lu_rs2_unused", ONone, ClsNone);
        clear_in();

        bus.alu_valid = 1'b1; bus.alu_is_div = 1'b1;
        for (int i = 0; i < 32; i++) step("div_stall", OMc, ClsMc);
        step("div_done", ODone, ClsNone);
        clear_in();
        step("div_idle", ONone, ClsNone);

        bus.alu_valid = 1'b1; bus.alu_is_mul = 1'b1;
        for (int i = 0; i < 2; i++) step("mul_stall", OMc, ClsMc);
        step("mul_done", ODone, ClsNone);
        clear_in();

        set_load(5'd9);
        bus.id_rs1_used = 1'b1; bus.id_rs1_addr = 5'd9;
        bus.alu_redirect = 1'b1;
        step("redirect_over_lu", ORd, ClsNone);
        bus.mem_busy = 1'b1;
        step("mem_over_redirect", OMem, ClsMw);
        clear_in();

        bus.alu_valid = 1'b1; bus.alu_is_div = 1'b1;
        for (int i = 0; i < 22; i++) step("div2_pre", OMc, ClsMc);
        chk("div2_mc_cnt", 32'(u_dut.mc_cnt_q), 32'd10);
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("div2_memwait", OMem, ClsMw);
            chk("div2_mc_cnt_frozen", 32'(u_dut.mc_cnt_q), 32'd10);
        end
        bus.mem_busy = 1'b0;
        for (int i = 0; i < 10; i++) step("div2_post", OMc, ClsMc);
        step("div2_done", ODone, ClsNone);
        clear_in();

        bus.alu_valid = 1'b1; bus.alu_is_div = 1'b1; bus.alu_is_mul = 1'b1;
        for (int i = 0; i < 5; i++) step("div3_stall", OMc, ClsMc);
        rst_n = 1'b1;
        step("div3_reset", ONone, ClsRst);
        rst_n = 1'b0;
        clear_in();
        step("div3_abandoned", ONone, ClsNone);

        bus.mem_busy = 1'b1;
        for (int i = 0; i < 66; i++) step("memwait_sat", OMem, ClsMw);
        chk("memwait_sat_final", 32'(bus.cnt_memwait), 32'd63);
        clear_in();
        step("final_idle", ONone, ClsNone);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
